// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 receiver slice.
// Prefix codes and frame length used by the frame FSM and testbench.
package ps2_pkg;
    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_BRK        = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;
endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronisers for the PS/2 pins plus a ps2_clk stability filter.
// 'fall' pulses for one cycle when the filtered clock goes 1->0.
module ps2_sync_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic clrn,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_s,
    output logic fall
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    ck_q;
    logic [1:0]    dt_q;
    logic          filt_q;
    logic [CW-1:0] cnt_q;
    logic          fall_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ck_q   <= 2'b11;
            dt_q   <= 2'b11;
            filt_q <= 1'b1;
            cnt_q  <= '0;
            fall_q <= 1'b0;
        end else begin
            ck_q   <= {ck_q[0], ps2_clk};
            dt_q   <= {dt_q[0], ps2_data};
            fall_q <= 1'b0;
            // Accept a new level only after FILTER_LEN consecutive differing cycles
            if (ck_q[1] != filt_q) begin
                if (cnt_q == CW'(FILTER_LEN - 1)) begin
                    filt_q <= ck_q[1];
                    cnt_q  <= '0;
                    fall_q <= filt_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign data_s = dt_q[1];
    assign fall   = fall_q;
endmodule

// File: rtl/ps2_rx_fifo_param.sv
// PS/2 device-to-host receiver: frame FSM, watchdog, optional prefix folding
// and a parametrised scan-code FIFO with sticky error flags.
module ps2_rx_fifo_param
    import ps2_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 50000,
    parameter int DECODE_PFX = 0,
    localparam int DW        = 8 + 2 * DECODE_PFX
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    input  logic                     nextdata_n,
    input  logic                     err_clr,
    output logic [DW-1:0]            data,
    output logic                     ready,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     overflow,
    output logic                     frame_err,
    output logic                     parity_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    logic data_s, fall;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
        .clk     (clk),
        .clrn    (clrn),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .data_s  (data_s),
        .fall    (fall)
    );

    logic [3:0]    bc_q;
    logic [9:0]    sh_q;
    logic [WW-1:0] wd_q;

    logic       last, start_bad, stop_bad, par_bad, good, wd_abort;
    logic [7:0] code;

    assign last      = fall && (bc_q == 4'(PS2_FRAME_BITS - 1));
    assign start_bad = sh_q[0];
    assign stop_bad  = !data_s;
    assign par_bad   = !(^sh_q[9:1]);
    assign good      = last && !start_bad && !stop_bad && !par_bad;
    assign code      = sh_q[8:1];
    assign wd_abort  = !fall && (bc_q != 4'd0) && (wd_q == WW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bc_q <= '0;
            sh_q <= '0;
            wd_q <= '0;
        end else if (fall) begin
            wd_q <= '0;
            if (last) begin
                bc_q <= '0;
            end else begin
                sh_q <= {data_s, sh_q[9:1]};
                bc_q <= bc_q + 4'd1;
            end
        end else if (bc_q == 4'd0) begin
            wd_q <= '0;
        end else if (wd_abort) begin
            bc_q <= '0;
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 1'b1;
        end
    end

    logic          push;
    logic [DW-1:0] wdata;

    if (DECODE_PFX != 0) begin : g_pfx
        logic ext_q, brk_q;
        logic is_ext, is_brk;

        assign is_ext = (code == PS2_EXT);
        assign is_brk = (code == PS2_BRK);
        assign push   = good && !is_ext && !is_brk;
        assign wdata  = {ext_q, brk_q, code};

        always_ff @(posedge clk or negedge clrn) begin
            if (!clrn) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (wd_abort || push) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (good) begin
                ext_q <= ext_q | is_ext;
                brk_q <= brk_q | is_brk;
            end
        end
    end else begin : g_raw
        assign push  = good;
        assign wdata = code;
    end

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [FW-1:0] fill_q, fill_d;
    logic          ready_q, ovf_q, fe_q, pe_q;
    logic          pop, full, wr, ovf_ev, fe_ev, pe_ev;

    assign pop    = ready_q && !nextdata_n;
    assign full   = (fill_q == FW'(DEPTH));
    // A push at full still lands when a pop frees the head slot this cycle
    assign wr     = push && (!full || pop);
    assign ovf_ev = push && full && !pop;
    assign fe_ev  = (last && (start_bad || stop_bad)) || wd_abort;
    assign pe_ev  = last && !start_bad && !stop_bad && par_bad;
    assign fill_d = fill_q + FW'(wr) - FW'(pop);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wp_q    <= '0;
            rp_q    <= '0;
            fill_q  <= '0;
            ready_q <= 1'b0;
            ovf_q   <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            if (wr)  wp_q <= wp_q + 1'b1;
            if (pop) rp_q <= rp_q + 1'b1;
            fill_q  <= fill_d;
            ready_q <= (fill_d != '0);
            ovf_q   <= ovf_ev | (ovf_q & ~err_clr);
            fe_q    <= fe_ev  | (fe_q  & ~err_clr);
            pe_q    <= pe_ev  | (pe_q  & ~err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wp_q] <= wdata;
    end

    assign data       = mem[rp_q];
    assign ready      = ready_q;
    assign fill       = fill_q;
    assign overflow   = ovf_q;
    assign frame_err  = fe_q;
    assign parity_err = pe_q;
endmodule

// File: tb/tb_ps2_rx_fifo_param.sv
// Self-checking bench: bit-banged PS/2 frames against a queue-based model.
// A second instance with prefix folding shares the PS/2 pins.
module tb_ps2_rx_fifo_param;
    localparam int H  = 12;
    localparam int TO = 300;

    logic clk = 1'b0;
    logic clrn = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic nd0 = 1'b1, nd1 = 1'b1;
    logic ec0 = 1'b0, ec1 = 1'b0;

    logic [7:0] data0;
    logic [9:0] data1;
    logic [3:0] fill0, fill1;
    logic rdy0, ovf0, fe0, pe0;
    logic rdy1, ovf1, fe1, pe1;

    always #5 clk = ~clk;

    ps2_rx_fifo_param #(.DEPTH(8), .FILTER_LEN(4), .TIMEOUT(TO), .DECODE_PFX(0)) u0 (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .nextdata_n(nd0), .err_clr(ec0), .data(data0), .ready(rdy0), .fill(fill0),
        .overflow(ovf0), .frame_err(fe0), .parity_err(pe0)
    );

    ps2_rx_fifo_param #(.DEPTH(8), .FILTER_LEN(4), .TIMEOUT(TO), .DECODE_PFX(1)) u1 (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .nextdata_n(nd1), .err_clr(ec1), .data(data1), .ready(rdy1), .fill(fill1),
        .overflow(ovf1), .frame_err(fe1), .parity_err(pe1)
    );

    int cmp = 0;
    int bad = 0;

    logic [7:0] mq[$];
    bit m_ovf, m_fe, m_pe;

    // kind: 0 good, 1 parity flipped, 2 stop low, 3 start high
    function automatic logic [10:0] mk(input logic [7:0] c, input int kind);
        logic [10:0] b;
        b[0]   = (kind == 3);
        b[8:1] = c;
        b[9]   = (~^c) ^ (kind == 1);
        b[10]  = (kind != 2);
        return b;
    endfunction

    task automatic model_frame(input logic [10:0] b);
        if (b[0] || !b[10]) m_fe = 1'b1;
        else if (!(^b[9:1])) m_pe = 1'b1;
        else if (mq.size() < 8) mq.push_back(b[8:1]);
        else m_ovf = 1'b1;
    endtask

    task automatic model_clear();
        mq.delete();
        m_ovf = 1'b0;
        m_fe = 1'b0;
        m_pe = 1'b0;
    endtask

    task automatic send_bits(input logic [10:0] b, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ps2_data = b[i];
            repeat (H / 2) @(negedge clk);
            if (glitch) begin
                ps2_clk = 1'b0;
                repeat (2) @(negedge clk);
                ps2_clk = 1'b1;
            end
            repeat (H / 2) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (H) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] c, input int kind, input bit glitch);
        logic [10:0] b;
        b = mk(c, kind);
        send_bits(b, 11, glitch);
        model_frame(b);
    endtask

    task automatic pop0();
        @(negedge clk) nd0 = 1'b0;
        @(negedge clk) nd0 = 1'b1;
        void'(mq.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk) clrn = 1'b0;
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        repeat (2) @(negedge clk);
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        cmp++;
        if ({fill0, rdy0, ovf0, fe0, pe0} !== 8'h00) begin
            bad++;
            $display("FAIL reset: got %h want 00", {fill0, rdy0, ovf0, fe0, pe0});
        end
    endtask

    task automatic test_basic();
        logic [10:0] b;
        b = mk(8'h1C, 0);
        send_bits(b, 10, 1'b0);
        cmp++;
        if (rdy0 !== 1'b0) begin
            bad++;
            $display("FAIL basic_pre_stop: ready=%b want 0", rdy0);
        end
        send_bits(b >> 10, 1, 1'b0);
        model_frame(b);
        cmp++;
        if ({rdy0, fill0, data0} !== {1'b1, 4'd1, 8'h1C}) begin
            bad++;
            $display("FAIL basic_push: rdy=%b fill=%0d data=%h want 1/1/1c", rdy0, fill0, data0);
        end
        pop0();
        cmp++;
        if ({rdy0, fill0} !== 5'b0_0000) begin
            bad++;
            $display("FAIL basic_pop: rdy=%b fill=%0d want 0/0", rdy0, fill0);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 9; i++) send(8'(i), 0, 1'b0);
        cmp++;
        if ({fill0, ovf0} !== {4'd8, 1'b1}) begin
            bad++;
            $display("FAIL ovf_full: fill=%0d ovf=%b want 8/1", fill0, ovf0);
        end
        for (int i = 1; i <= 8; i++) begin
            cmp++;
            if (data0 !== mq[0]) begin
                bad++;
                $display("FAIL ovf_order[%0d]: got %h want %h", i, data0, mq[0]);
            end
            pop0();
        end
        cmp++;
        if (rdy0 !== 1'b0) begin
            bad++;
            $display("FAIL ovf_empty: ready=%b want 0", rdy0);
        end
    endtask

    task automatic test_parity();
        do_reset();
        send(8'h1C, 1, 1'b0);
        cmp++;
        if ({fill0, pe0, fe0} !== {4'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL parity: fill=%0d pe=%b fe=%b want 0/1/0", fill0, pe0, fe0);
        end
        @(negedge clk) ec0 = 1'b1;
        @(negedge clk) ec0 = 1'b0;
        m_pe = 1'b0;
        cmp++;
        if ({pe0, fe0} !== 2'b00) begin
            bad++;
            $display("FAIL err_clr: pe=%b fe=%b want 0/0", pe0, fe0);
        end
    endtask

    task automatic test_watchdog();
        logic [10:0] b;
        do_reset();
        b = mk(8'h5A, 0);
        send_bits(b, 6, 1'b0);
        repeat (TO + 50) @(negedge clk);
        cmp++;
        if ({fe0, fill0} !== {1'b1, 4'd0}) begin
            bad++;
            $display("FAIL watchdog: fe=%b fill=%0d want 1/0", fe0, fill0);
        end
        send(8'h1C, 0, 1'b0);
        cmp++;
        if ({fill0, data0} !== {4'd1, 8'h1C}) begin
            bad++;
            $display("FAIL wd_recover: fill=%0d data=%h want 1/1c", fill0, data0);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        send(8'h1C, 0, 1'b1);
        send(8'hA7, 0, 1'b1);
        cmp++;
        if ({fill0, data0, fe0, pe0} !== {4'd2, 8'h1C, 2'b00}) begin
            bad++;
            $display("FAIL glitch: fill=%0d data=%h fe=%b pe=%b want 2/1c/0/0",
                     fill0, data0, fe0, pe0);
        end
    endtask

    task automatic test_prefix();
        do_reset();
        send(8'hE0, 0, 1'b0);
        send(8'hF0, 0, 1'b0);
        send(8'h75, 0, 1'b0);
        cmp++;
        if ({fill1, data1} !== {4'd1, 10'h375}) begin
            bad++;
            $display("FAIL pfx_ext_brk: fill=%0d data=%h want 1/375", fill1, data1);
        end
        @(negedge clk) nd1 = 1'b0;
        @(negedge clk) nd1 = 1'b1;
        send(8'h75, 0, 1'b0);
        cmp++;
        if ({fill1, data1} !== {4'd1, 10'h075}) begin
            bad++;
            $display("FAIL pfx_plain: fill=%0d data=%h want 1/075", fill1, data1);
        end
    endtask

    task automatic test_random();
        int kind, npop;
        logic [7:0] c;
        do_reset();
        for (int it = 0; it < 24; it++) begin
            c = 8'($urandom_range(0, 255));
            kind = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 3);
            send(c, kind, $urandom_range(0, 1) == 1);
            cmp++;
            if ({fill0, rdy0, ovf0, fe0, pe0} !==
                {4'(mq.size()), mq.size() != 0, m_ovf, m_fe, m_pe}) begin
                bad++;
                $display("FAIL rand_state[%0d]: got %h want %h", it,
                         {fill0, rdy0, ovf0, fe0, pe0},
                         {4'(mq.size()), mq.size() != 0, m_ovf, m_fe, m_pe});
            end
            npop = $urandom_range(0, 1);
            for (int k = 0; k < npop && mq.size() != 0; k++) begin
                cmp++;
                if (data0 !== mq[0]) begin
                    bad++;
                    $display("FAIL rand_data[%0d]: got %h want %h", it, data0, mq[0]);
                end
                pop0();
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_parity();
        test_watchdog();
        test_glitch();
        test_prefix();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
